// File: rtl/bufcapture_if.sv
// bufcapture_if: bundles the capture, read-back and status signals of bufcapture.
//   master modport: host side (drives samples, control and read requests; sees status)
//   slave modport : bufcapture side
//   Signals: wdata/wen/trig (sample stream), arm/mode/posttrig (capture control),
//   decim (only with BUFCAPTURE_DECIM_EN), ren/raddr/rch -> rdv/rdata (read port),
//   busy/full/wrap/wptr/trigaddr (status).
interface bufcapture_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 10
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*DW-1:0] wdata;
    logic              wen;
    logic              arm;
    logic              mode;
    logic [AW-1:0]     posttrig;
    logic              trig;
`ifdef BUFCAPTURE_DECIM_EN
    logic [7:0]        decim;
`endif
    logic              ren;
    logic [AW-1:0]     raddr;
    logic [CW-1:0]     rch;
    logic              rdv;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic              full;
    logic              wrap;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     trigaddr;

    modport master (
        output wdata, wen, arm, mode, posttrig, trig,
`ifdef BUFCAPTURE_DECIM_EN
        output decim,
`endif
        output ren, raddr, rch,
        input  rdv, rdata, busy, full, wrap, wptr, trigaddr
    );

    modport slave (
        input  wdata, wen, arm, mode, posttrig, trig,
`ifdef BUFCAPTURE_DECIM_EN
        input  decim,
`endif
        input  ren, raddr, rch,
        output rdv, rdata, busy, full, wrap, wptr, trigaddr
    );
endinterface

// File: rtl/bufcapture.sv
// bufcapture: multi-channel capture buffer with armed fill and circular pre/post-trigger modes.
//   NCH channels of DW bits are sampled into a 2^AW-deep buffer. Fill mode stops when the
//   last address is written; circular mode runs until posttrig samples follow the trigger.
//   Read-back is random access with a fixed 2-cycle latency (read-first vs. a same-cycle write).
// Ports:
//   clk     : sole clock
//   reset_n : asynchronous active-low reset (buffer contents are not reset)
//   bus     : bufcapture_if.slave (sample stream, control, read port, status)
// Optional feature: define BUFCAPTURE_DECIM_EN to add the decim input and keep one sample
//   out of every (decim+1) wen samples.
module bufcapture #(
    parameter int unsigned DW  = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 10
) (
    input logic        clk,
    input logic        reset_n,
    bufcapture_if.slave bus
);
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [2:0] {StIdle, StFill, StPre, StPost, StDone} state_e;

    state_e        state_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] trigaddr_q;
    logic [AW-1:0] postcnt_q;
    logic [AW-1:0] posttrig_q;
    logic          wrap_q;
    logic          busy_q;
    logic          full_q;

    logic capturing;
    logic decim_ok;
    logic accept;
    logic last_addr;
    logic end_on_accept;

    assign capturing = (state_q == StFill) || (state_q == StPre) || (state_q == StPost);
    assign last_addr = &wptr_q;
    // arm wins over a coincident sample: that sample is dropped.
    assign accept    = bus.wen && capturing && decim_ok && !bus.arm;

`ifdef BUFCAPTURE_DECIM_EN
    logic [7:0] decim_cnt_q;

    assign decim_ok = (decim_cnt_q == 8'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decim_cnt_q <= 8'd0;
        end else if (bus.arm) begin
            decim_cnt_q <= 8'd0;
        end else if (bus.wen && capturing) begin
            decim_cnt_q <= decim_ok ? bus.decim : decim_cnt_q - 1'b1;
        end
    end
`else
    assign decim_ok = 1'b1;
`endif

    // Whether the sample being accepted this cycle completes the capture.
    always_comb begin
        end_on_accept = 1'b0;
        unique case (state_q)
            StFill:  end_on_accept = last_addr;
            StPre:   end_on_accept = bus.trig && (posttrig_q == '0);
            StPost:  end_on_accept = (postcnt_q == AW'(1));
            default: end_on_accept = 1'b0;
        endcase
    end

    // Capture FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            trigaddr_q <= '0;
            postcnt_q  <= '0;
            posttrig_q <= '0;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
        end else if (bus.arm) begin
            state_q    <= bus.mode ? StPre : StFill;
            wptr_q     <= '0;
            trigaddr_q <= '0;
            postcnt_q  <= '0;
            posttrig_q <= bus.posttrig;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b1;
            full_q     <= 1'b0;
        end else if (accept) begin
            wptr_q <= wptr_q + 1'b1;
            // A capture ending exactly on the last address leaves a contiguous 0..max
            // buffer, so wrap is only raised when writing continues past the top.
            if (last_addr && !end_on_accept) begin
                wrap_q <= 1'b1;
            end
            if (state_q == StPre && bus.trig) begin
                trigaddr_q <= wptr_q;
                postcnt_q  <= posttrig_q;
            end else if (state_q == StPost) begin
                postcnt_q <= postcnt_q - 1'b1;
            end
            if (end_on_accept) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                full_q  <= 1'b1;
            end else if (state_q == StPre && bus.trig) begin
                state_q <= StPost;
            end
        end
    end

    // Write path: sample and address registered once, RAM written the following cycle.
    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;
    logic [NCH*DW-1:0] wr_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= wptr_q;
                wr_data_q <= bus.wdata;
            end
        end
    end

    // All channels share one address, so each word holds one sample of every channel.
    logic [NCH*DW-1:0] mem_q [Depth];
    logic [NCH*DW-1:0] rd_word_q;

    // Read sits in the same block as the write: a same-cycle same-address read sees old data.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
        if (bus.ren) begin
            rd_word_q <= mem_q[bus.raddr];
        end
    end

    logic          rd_vld_q;
    logic [CW-1:0] rd_ch_q;
    logic          rdv_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        if (32'(rd_ch_q) < NCH) begin
            rd_sel = rd_word_q[rd_ch_q*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= 1'b0;
            rd_ch_q  <= '0;
            rdv_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rd_vld_q <= bus.ren;
            if (bus.ren) begin
                rd_ch_q <= bus.rch;
            end
            rdv_q <= rd_vld_q;
            if (rd_vld_q) begin
                rdata_q <= rd_sel;
            end
        end
    end

    assign bus.rdv      = rdv_q;
    assign bus.rdata    = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.wrap     = wrap_q;
    assign bus.wptr     = wptr_q;
    assign bus.trigaddr = trigaddr_q;
endmodule
